shift_sched_arbiter: RTL and testbench
======================================

Name: shift_sched_arbiter

Overview:
- Round-robin scheduler that shares one signed-shift datapath among NUM_REQ requesters, using valid/ready handshakes.
- Each request carries a data word and a 6-bit two's-complement shift code. The block decodes the code, applies the shift in a 2-stage pipeline and returns the result tagged with the requester index.
- Sits between the posit/float normalisation stages and the shared shifter. Saves one shifter per lane.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data width (≥8).
- ID_W, $clog2(NUM_REQ), tag width (derived; not overridable).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; drops all in-flight results
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready (one-hot or zero)
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i at [i*DATA_W +: DATA_W]
- req_code  in  NUM_REQ*6  packed shift codes; requester i at [i*6 +: 6]
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  shifted result
- out_id  out  ID_W  index of the requester that produced the result
- out_sat  out  1  shift magnitude ≥ DATA_W (result saturated to 0 / sign fill)
- in_flight  out  2  number of occupied pipeline stages (0..2)

Behaviour:
- Reset (async, rst=1): both stage valids=0; out_valid=0; out_data=0; out_id=0; out_sat=0; in_flight=0; RR pointer=NUM_REQ-1, so requester 0 has top priority first.
- Decode: shamt = signed 6-bit code, range -32..+31.
  - shamt>0: logical left shift by shamt.
  - shamt<0: arithmetic right shift by |shamt|.
  - shamt=0: pass-through.
  - |shamt| ≥ DATA_W: out_sat=1; result is 0 for a left shift, all-sign-bits for a right shift.
- Pipeline:
  - S1 registers {data, shamt, id}.
  - S2 registers {shifted data, sat, id}, which drive the out_* ports.
  - advance2 = !s2_valid | out_ready.
  - advance1 = !s1_valid | advance2.
  - Full throughput is 1 result/cycle. Latency is 2 cycles: accept at edge t, out_valid at t+2 when out_ready stays high.
  - When stalled, S2 contents and out_* hold stable while out_valid=1 (AXI-style; no change before the handshake).
- Arbitration (combinational):
  - Grant = first requester with req_valid=1, searching from pointer+1 cyclically.
  - req_ready[i] = grant[i] & advance1.
  - A requester must hold valid/data/code until it sees ready; the arbiter never revokes ready while valid is held and advance1 holds.
  - The pointer updates to the granted index only on an accepted transfer (valid&ready). No update on stall or when no request is pending.
- in_flight = s1_valid + s2_valid.
- Simultaneous events:
  - An S2 drain and an S1 refill in the same cycle are legal.
  - A new accept in the same cycle as an S1→S2 move is legal.
- flush=1:
  - Next cycle: s1_valid=s2_valid=0, out_valid=0.
  - req_ready is forced to 0 during the flush cycle; no accept.
  - The RR pointer is not changed.
- Reset mid-operation: all in-flight work is discarded immediately (async). No partial output is produced after rst deasserts.

Decomposition:
- Package shift_sched_pkg:
  - SHCODE_W=6 constant.
  - typedef shamt_t (logic signed [5:0]).
  - typedef struct s1_t {data, shamt, id}.
  - function sat_check(shamt, DATA_W).
- One sub-module: rr_priority_picker.
  - Parameterised on NUM_REQ.
  - Inputs: valid vector and pointer. Outputs: one-hot grant, index, any_grant.
  - Purely combinational; reusable by other shared resources.

Test Plan:
- Single requester 1, data=32'h0000_00F0, code=6'd4, out_ready=1 → out_valid 2 cycles after accept, out_data=32'h0000_0F00, out_id=1, out_sat=0.
- Code=6'b111100 (-4), data=32'h8000_0000 → out_data=32'hF800_0000. Code=6'd31 with DATA_W=32 → no sat, out_data = data<<31. Code=6'b100000 (-32) → out_sat=1, result = sign fill (32'hFFFF_FFFF).
- All 4 requesters valid continuously, out_ready=1 → grant order 0,1,2,3,0,…; one result per cycle; out_id sequence matches the grant order.
- out_ready=0 for 5 cycles with the pipeline full → in_flight=2, all req_ready=0, out_data/out_id stable. On release, results are drained in order with no loss or duplication.
- Requester 2 waiting while the pipeline stalls → pointer does not advance and req_ready[2]=0. After release, requester 2 is accepted before requester 3.
- flush asserted with in_flight=2; separately, rst pulsed mid-stream → out_valid=0 next cycle (flush) or immediately (rst). After reset, the first grant goes to requester 0.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the round-robin shift scheduler.
// Struct fields are sized for the widest supported lane (64-bit data, 8 requesters).
package shift_sched_pkg;

  localparam int SHCODE_W   = 6;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ID_W   = 3;

  typedef logic signed [SHCODE_W-1:0] shamt_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    shamt_t                shamt;
    logic [MAX_ID_W-1:0]   id;
  } s1_t;

  // True when the shift magnitude pushes every data bit out of the word.
  function automatic logic sat_check(input shamt_t shamt, input int dataW);
    int mag;
    mag = (shamt < 0) ? -int'(shamt) : int'(shamt);
    return (mag >= dataW);
  endfunction

endpackage

// File: rtl/shift_sched_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid requester after the pointer wins.
// Kept free of datapath detail so other shared resources can reuse it.
module rr_priority_picker
  import shift_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   index_o,
  output logic               anyGrant_o
);

  logic [IDX_W-1:0] cand;

  // Walk the ring starting one past the last winner; the pointer itself is searched last.
  always_comb begin
    grant_o    = '0;
    index_o    = '0;
    anyGrant_o = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!anyGrant_o && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        index_o       = cand;
        anyGrant_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_sched_arbiter.sv
// Shares one signed-shift datapath among NUM_REQ requesters with a round-robin
// grant and a two-stage valid/ready pipeline (operand capture, then shifted result).
module shift_sched_arbiter
  import shift_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHCODE_W-1:0] req_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_sat,
  output logic [1:0]                 in_flight
);

  logic [DATA_W-1:0] reqDataArr [NUM_REQ];
  shamt_t            reqCodeArr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantIdx;
  logic               anyGrant;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              s1Valid_q, s1Valid_d;
  s1_t               s1_q, s1_d;
  logic              s2Valid_q, s2Valid_d;
  logic [DATA_W-1:0] s2Data_q, s2Data_d;
  logic              s2Sat_q, s2Sat_d;
  logic [ID_W-1:0]   s2Id_q, s2Id_d;

  logic advance1, advance2, accept;

  logic [DATA_W-1:0]         shiftIn, shiftOut;
  shamt_t                    shAmt;
  logic signed [SHCODE_W:0]  shExt;
  logic [SHCODE_W:0]         shMag;
  logic                      shSat;
  logic                      unusedBits;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqDataArr[g] = req_data[g*DATA_W +: DATA_W];
    assign reqCodeArr[g] = shamt_t'(req_code[g*SHCODE_W +: SHCODE_W]);
  end

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .valid_i   (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .index_o   (grantIdx),
    .anyGrant_o(anyGrant)
  );

  assign advance2  = !s2Valid_q || out_ready;
  assign advance1  = !s1Valid_q || advance2;
  assign accept    = anyGrant && advance1 && !flush;
  assign req_ready = (flush || !advance1) ? '0 : grant;

  // Saturated codes are handled explicitly so the result never depends on
  // how a shift by a full word width is evaluated.
  always_comb begin
    shiftIn  = s1_q.data[DATA_W-1:0];
    shAmt    = s1_q.shamt;
    shExt    = {shAmt[SHCODE_W-1], shAmt};
    shMag    = shExt[SHCODE_W] ? -shExt : shExt;
    shSat    = sat_check(shAmt, DATA_W);
    shiftOut = shiftIn;
    if (shSat) begin
      shiftOut = shAmt[SHCODE_W-1] ? {DATA_W{shiftIn[DATA_W-1]}} : '0;
    end else if (shAmt[SHCODE_W-1]) begin
      shiftOut = $signed(shiftIn) >>> shMag;
    end else begin
      shiftOut = shiftIn << shMag;
    end
  end

  // S2 only reloads from a valid S1 so the result registers hold across bubbles.
  always_comb begin
    ptr_d     = ptr_q;
    s1Valid_d = s1Valid_q;
    s1_d      = s1_q;
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    s2Sat_d   = s2Sat_q;
    s2Id_d    = s2Id_q;
    if (flush) begin
      s1Valid_d = 1'b0;
      s2Valid_d = 1'b0;
    end else begin
      if (advance2) begin
        s2Valid_d = s1Valid_q;
        if (s1Valid_q) begin
          s2Data_d = shiftOut;
          s2Sat_d  = shSat;
          s2Id_d   = s1_q.id[ID_W-1:0];
        end
      end
      if (advance1) begin
        s1Valid_d = accept;
      end
      if (accept) begin
        s1_d                   = '0;
        s1_d.data[DATA_W-1:0]  = reqDataArr[grantIdx];
        s1_d.shamt             = reqCodeArr[grantIdx];
        s1_d.id[ID_W-1:0]      = grantIdx;
        ptr_d                  = grantIdx;
      end
    end
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= ID_W'(NUM_REQ - 1);
      s1Valid_q <= 1'b0;
      s1_q      <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Sat_q   <= 1'b0;
      s2Id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1Valid_q <= s1Valid_d;
      s1_q      <= s1_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      s2Sat_q   <= s2Sat_d;
      s2Id_q    <= s2Id_d;
    end
  end

  assign out_valid  = s2Valid_q;
  assign out_data   = s2Data_q;
  assign out_id     = s2Id_q;
  assign out_sat    = s2Sat_q;
  assign in_flight  = {1'b0, s1Valid_q} + {1'b0, s2Valid_q};
  assign unusedBits = ^{s1_q.data, s1_q.id};

endmodule

// File: tb/tb_shift_sched_arbiter.sv
// Directed bench for shift_sched_arbiter: a negedge monitor fills a scoreboard on
// every accepted request and checks each emitted result against it in order.
module tb_shift_sched_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic            sat;
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } expect_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [127:0]         req_data;
  logic [23:0]          req_code;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_sat;
  logic [1:0]           in_flight;

  logic [31:0] reqDataArr [NUM_REQ];
  logic [5:0]  reqCodeArr [NUM_REQ];

  expect_t sbQ[$];
  int      grantLog[$];
  int      testsRun    = 0;
  int      testsFailed = 0;

  assign req_data = {reqDataArr[3], reqDataArr[2], reqDataArr[1], reqDataArr[0]};
  assign req_code = {reqCodeArr[3], reqCodeArr[2], reqCodeArr[1], reqCodeArr[0]};

  always #5 clk = ~clk;

  shift_sched_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_code (req_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_sat  (out_sat),
    .in_flight(in_flight)
  );

  // Reference shift on a 64-bit widened word, so saturation falls out naturally.
  function automatic expect_t modelShift(input logic [31:0] d, input logic [5:0] c, input int id);
    int                 s;
    logic signed [63:0] w;
    expect_t            e;
    s    = int'($signed(c));
    e.id = ID_W'(id);
    if (s >= 0) begin
      w      = {32'b0, d};
      w      = w << s;
      e.data = w[31:0];
      e.sat  = (s >= 32);
    end else begin
      w      = {{32{d[31]}}, d};
      w      = w >>> (-s);
      e.data = w[31:0];
      e.sat  = ((-s) >= 32);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request on lane idx and hold it until the handshake completes.
  task automatic applyStimulus(input int idx, input logic [31:0] d, input logic [5:0] c);
    int waited;
    waited          = 0;
    reqDataArr[idx] = d;
    reqCodeArr[idx] = c;
    req_valid[idx]  = 1'b1;
    @(negedge clk);
    while (!req_ready[idx] && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) checkOutput("accept_timeout", 64'(req_ready[idx]), 64'(1));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (sbQ.size() == 0 && !out_valid) break;
    end
    checkOutput(tag, 64'(sbQ.size()), 64'(0));
  endtask

  // Monitor: retire results first, then record new accepts, then honour flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
    end else begin
      if (out_valid) begin
        checkOutput("sb_has_entry", 64'(sbQ.size() != 0), 64'(1));
        if (sbQ.size() != 0) begin
          checkOutput("result", 64'({out_sat, out_id, out_data}), 64'(sbQ[0]));
          if (out_ready) void'(sbQ.pop_front());
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbQ.push_back(modelShift(reqDataArr[i], reqCodeArr[i], i));
          grantLog.push_back(i);
        end
      end
      if (flush) sbQ.delete();
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqDataArr[i] = '0;
      reqCodeArr[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_out_id", 64'(out_id), 64'(0));
    checkOutput("rst_out_sat", 64'(out_sat), 64'(0));
    checkOutput("rst_in_flight", 64'(in_flight), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request on lane 1: two-cycle latency and a plain left shift.
    reqDataArr[1] = 32'h0000_00F0;
    reqCodeArr[1] = 6'd4;
    req_valid[1]  = 1'b1;
    @(negedge clk);
    checkOutput("t1_ready", 64'(req_ready), 64'(4'b0010));
    checkOutput("t1_valid_c0", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("t1_in_flight", 64'(in_flight), 64'(1));
    checkOutput("t1_valid_c1", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("t1_valid_c2", 64'(out_valid), 64'(1));
    checkOutput("t1_data", 64'(out_data), 64'(32'h0000_0F00));
    checkOutput("t1_id", 64'(out_id), 64'(1));
    checkOutput("t1_sat", 64'(out_sat), 64'(0));
    waitDrain("t1_drain");

    // Shift-code corners on lane 0, issued back to back.
    applyStimulus(0, 32'h8000_0000, 6'b111100);
    applyStimulus(0, 32'h0000_0003, 6'd31);
    applyStimulus(0, 32'h8000_0001, 6'b100000);
    applyStimulus(0, 32'h7FFF_FFFF, 6'b100000);
    applyStimulus(0, 32'h1234_5678, 6'd0);
    waitDrain("t2_drain");

    // All lanes busy: after lane 0 won last, rotation is 1,2,3,0,...
    grantLog.delete();
    for (int i = 0; i < NUM_REQ; i++) reqDataArr[i] = 32'(i + 1) * 32'h0101_0101;
    reqCodeArr[0] = 6'd1;
    reqCodeArr[1] = 6'h3F;
    reqCodeArr[2] = 6'd8;
    reqCodeArr[3] = 6'h38;
    req_valid     = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 2) checkOutput("thru_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    req_valid = '0;
    checkOutput("thru_count", 64'(grantLog.size()), 64'(8));
    for (int k = 0; k < 8 && k < grantLog.size(); k++)
      checkOutput("thru_order", 64'(grantLog[k]), 64'((1 + k) % 4));
    waitDrain("t3_drain");

    // Fill the pipeline against a stalled sink, then hold lanes 2 and 3 waiting.
    out_ready = 1'b0;
    applyStimulus(1, 32'h0000_00A5, 6'd1);
    applyStimulus(0, 32'h0000_005A, 6'h3F);
    reqDataArr[2] = 32'h0000_0222;
    reqCodeArr[2] = 6'd2;
    reqDataArr[3] = 32'h8000_0333;
    reqCodeArr[3] = 6'h3E;
    req_valid[2]  = 1'b1;
    req_valid[3]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_flight", 64'(in_flight), 64'(2));
      checkOutput("stall_ready", 64'(req_ready), 64'(0));
      checkOutput("stall_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    grantLog.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_ready2", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    checkOutput("release_ready3", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    waitDrain("t4_drain");
    checkOutput("release_count", 64'(grantLog.size()), 64'(2));
    if (grantLog.size() >= 2) begin
      checkOutput("release_first", 64'(grantLog[0]), 64'(2));
      checkOutput("release_second", 64'(grantLog[1]), 64'(3));
    end

    // Flush with both stages occupied; lane 3 must not be accepted meanwhile.
    out_ready = 1'b0;
    applyStimulus(1, 32'h0000_C0DE, 6'd3);
    applyStimulus(2, 32'h0000_BEEF, 6'h3D);
    @(negedge clk);
    checkOutput("flush_full", 64'(in_flight), 64'(2));
    @(posedge clk); #1;
    flush         = 1'b1;
    reqDataArr[3] = 32'h0000_0F0F;
    reqCodeArr[3] = 6'd4;
    req_valid[3]  = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    flush        = 1'b0;
    req_valid[3] = 1'b0;
    out_ready    = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    checkOutput("flush_in_flight", 64'(in_flight), 64'(0));
    @(posedge clk); #1;
    reqDataArr[0] = 32'h0000_0001;
    reqCodeArr[0] = 6'd5;
    req_valid[0]  = 1'b1;
    req_valid[3]  = 1'b1;
    @(negedge clk);
    checkOutput("flush_ptr_kept", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(negedge clk);
    checkOutput("flush_next_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitDrain("t5_drain");

    // Reset in the middle of a busy stream.
    req_valid = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_async_in_flight", 64'(in_flight), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_first_grant", 64'(req_ready), 64'(4'b0001));
    checkOutput("rst_no_output", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    req_valid = '0;
    waitDrain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
